// File: rtl/apb_cmd_queue_if.sv
// Command/engine/response signal bundle for apb_cmd_queue.
// slave: the queue's view. master: the view of whatever drives commands,
// plays the transaction engine and consumes responses.
interface apb_cmd_queue_if;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 5;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [DW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          start_write;
  logic          start_read;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          done;
  logic [DW-1:0] rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] count;
  logic          busy;
  logic          err_timeout;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, done, rdata, rsp_ready,
    output cmd_ready, start_write, start_read, addr, wdata, rsp_valid, rsp_data,
           count, busy, err_timeout
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, done, rdata, rsp_ready,
    input  cmd_ready, start_write, start_read, addr, wdata, rsp_valid, rsp_data,
           count, busy, err_timeout
  );
endinterface

// File: rtl/apb_cmd_queue.sv
// apb_cmd_queue: DEPTH-entry command FIFO feeding a one-at-a-time APB
// transaction engine. Head entry stays queued until its transaction
// completes; read data is held in a response register until consumed.
// Optional feature: define APB_CMD_TIMEOUT_EN to abandon a transaction
// after TIMEOUT cycles in WAIT and raise a sticky err_timeout.
module apb_cmd_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  apb_cmd_queue_if.slave bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 5;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic          write;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Reject configurations the pointer/count arithmetic cannot support
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("apb_cmd_queue: DEPTH must be a power of 2 in 2..16 and TIMEOUT >= 1");
  end

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  cmd_t          head;
  logic          push, pop;

  state_t        state, state_d;
  logic          start_write_q, start_write_d;
  logic          start_read_q, start_read_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          busy_q, busy_d;

`ifdef APB_CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  assign bus.cmd_ready = (count_q != CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem[rd_ptr];

  // Queue storage; the slot at wr_ptr is never the in-flight head
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wr_ptr] <= '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    end
  end

  // Pointers and occupancy (count includes the entry in flight)
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      start_write_q <= 1'b0;
      start_read_q  <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      busy_q        <= 1'b0;
`ifdef APB_CMD_TIMEOUT_EN
      tmo_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      start_write_q <= start_write_d;
      start_read_q  <= start_read_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      busy_q        <= busy_d;
`ifdef APB_CMD_TIMEOUT_EN
      tmo_q         <= tmo_d;
      err_q         <= err_d;
`endif
    end
  end

  // Next state, next output values and the pop decision
  always_comb begin
    state_d       = state;
    start_write_d = 1'b0;
    start_read_d  = 1'b0;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    pop           = 1'b0;
`ifdef APB_CMD_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_d         = err_q;
`endif

    case (state)
      IDLE: begin
        addr_d  = '0;
        wdata_d = '0;
        if (count_q != '0) begin
          state_d       = ISSUE;
          start_write_d = head.write;
          start_read_d  = !head.write;
          addr_d        = head.addr;
          wdata_d       = head.write ? head.wdata : '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef APB_CMD_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.done) begin
          pop     = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
          if (head.write) begin
            state_d = IDLE;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.rdata;
          end
        end
`ifdef APB_CMD_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Abandon the transaction: drop the entry, no response
          pop     = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.start_write = start_write_q;
  assign bus.start_read  = start_read_q;
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.count       = count_q;
  assign bus.busy        = busy_q;
`ifdef APB_CMD_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Self-checking bench for apb_cmd_queue: directed scenarios plus a
// randomized run checked against a transaction-level queue model.
module tb_apb_cmd_queue;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } tcmd_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] issued [$];

  always #5 clk = ~clk;

  apb_cmd_queue_if bus ();

  apb_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus.slave)
  );

  // Record the address of every issued transaction, in order
  always @(negedge clk) begin
    if (bus.start_write || bus.start_read) issued.push_back(bus.addr);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_wdata = 8'h00;
    bus.done = 1'b0; bus.rdata = 8'h00; bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer a command until accepted (bounded)
  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
  endtask

  // Advance until a start pulse is visible (bounded)
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.start_write || bus.start_read) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // From the ISSUE cycle: one WAIT cycle, then a done pulse
  task automatic finish_txn(input logic [7:0] rd);
    tick();
    bus.done = 1'b1; bus.rdata = rd;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.cmd_valid = 1'b1; bus.cmd_addr = 8'h77;
    tick();
    tick();
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    tests++; if ({bus.start_write, bus.start_read, bus.rsp_valid, bus.busy, bus.err_timeout} !== 5'b0)
      begin fails++; $display("FAIL reset_flags: got %b want 00000", {bus.start_write, bus.start_read, bus.rsp_valid, bus.busy, bus.err_timeout}); end
    tests++; if ({bus.addr, bus.wdata, bus.rsp_data} !== 24'h0)
      begin fails++; $display("FAIL reset_data: got %h want 000000", {bus.addr, bus.wdata, bus.rsp_data}); end
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h10; bus.cmd_wdata = 8'hAB;
    tick();
    bus.cmd_valid = 1'b0;
    tests++; if (bus.start_write !== 1'b0) begin fails++; $display("FAIL write_early_start: got %b want 0", bus.start_write); end
    tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL write_count_1: got %0d want 1", bus.count); end
    tick();
    tests++; if ({bus.start_write, bus.start_read} !== 2'b10) begin fails++; $display("FAIL write_start: got %b want 10", {bus.start_write, bus.start_read}); end
    tests++; if (bus.addr !== 8'h10 || bus.wdata !== 8'hAB) begin fails++; $display("FAIL write_addr_data: got %h/%h want 10/ab", bus.addr, bus.wdata); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL write_busy: got %b want 1", bus.busy); end
    tick();
    tests++; if (bus.start_write !== 1'b0 || bus.addr !== 8'h10 || bus.wdata !== 8'hAB)
      begin fails++; $display("FAIL write_wait_hold: got sw=%b %h/%h want 0 10/ab", bus.start_write, bus.addr, bus.wdata); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tests++; if (bus.count !== 5'd0 || bus.busy !== 1'b0) begin fails++; $display("FAIL write_done: got count=%0d busy=%b want 0 0", bus.count, bus.busy); end
    tests++; if (bus.addr !== 8'h00) begin fails++; $display("FAIL write_idle_addr: got %h want 00", bus.addr); end
    tick();
    tests++; if (bus.start_write !== 1'b0) begin fails++; $display("FAIL write_no_reissue: got %b want 0", bus.start_write); end
  endtask

  task automatic test_read_resp();
    bit ok;
    push(1'b0, 8'h10, 8'hEE, ok);
    wait_start(ok);
    tests++; if (!ok || {bus.start_write, bus.start_read} !== 2'b01) begin fails++; $display("FAIL read_start: got %b want 01", {bus.start_write, bus.start_read}); end
    tests++; if (bus.addr !== 8'h10 || bus.wdata !== 8'h00) begin fails++; $display("FAIL read_addr_wdata: got %h/%h want 10/00", bus.addr, bus.wdata); end
    finish_txn(8'hAB);
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hAB)
        begin fails++; $display("FAIL read_rsp_hold%0d: got v=%b d=%h want 1 ab", i, bus.rsp_valid, bus.rsp_data); end
      tests++; if (bus.start_write !== 1'b0) begin fails++; $display("FAIL read_no_issue_in_resp%0d: got %b want 0", i, bus.start_write); end
      bus.cmd_valid = (i == 0); bus.cmd_write = 1'b1; bus.cmd_addr = 8'h20; bus.cmd_wdata = 8'h21;
      bus.done = 1'b1; bus.rdata = 8'h5A;
      tick();
    end
    bus.cmd_valid = 1'b0; bus.done = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tests++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00) begin fails++; $display("FAIL read_rsp_clear: got v=%b d=%h want 0 00", bus.rsp_valid, bus.rsp_data); end
    wait_start(ok);
    tests++; if (!ok || bus.start_write !== 1'b1 || bus.addr !== 8'h20) begin fails++; $display("FAIL read_next_issue: got sw=%b a=%h want 1 20", bus.start_write, bus.addr); end
    finish_txn(8'h00);
  endtask

  task automatic test_fill();
    bit ok;
    int base;
    do_reset();
    base = issued.size();
    for (int k = 1; k <= 4; k++) begin
      push(1'b1, 8'(k), 8'(8'hA0 + k), ok);
      tests++; if (!ok) begin fails++; $display("FAIL fill_push%0d: got not-accepted want accepted", k); end
    end
    tests++; if (bus.cmd_ready !== 1'b0 || bus.count !== 5'd4) begin fails++; $display("FAIL fill_full: got rdy=%b count=%0d want 0 4", bus.cmd_ready, bus.count); end
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h05; bus.cmd_wdata = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.count !== 5'd4) begin fails++; $display("FAIL fill_stall%0d: got count=%0d want 4", i, bus.count); end
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tests++; if (bus.count !== 5'd3 || bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL fill_after_done: got count=%0d rdy=%b want 3 1", bus.count, bus.cmd_ready); end
    tick();
    bus.cmd_valid = 1'b0;
    tests++; if (bus.count !== 5'd4) begin fails++; $display("FAIL fill_fifth_accept: got count=%0d want 4", bus.count); end
    for (int k = 0; k < 4; k++) begin
      wait_start(ok);
      tests++; if (!ok) begin fails++; $display("FAIL fill_drain%0d: got no start want start", k); end
      finish_txn(8'h00);
    end
    tests++; if (issued.size() != base + 5) begin fails++; $display("FAIL fill_issue_count: got %0d want 5", issued.size() - base); end
    for (int k = 0; k < 5 && base + k < issued.size(); k++) begin
      tests++; if (issued[base + k] !== 8'(k + 1)) begin fails++; $display("FAIL fill_order%0d: got %h want %h", k, issued[base + k], 8'(k + 1)); end
    end
  endtask

  task automatic test_simul();
    bit ok;
    int base;
    do_reset();
    base = issued.size();
    for (int k = 1; k <= 3; k++) push(1'b1, 8'(8'h30 + k), 8'(k), ok);
    tests++; if (bus.count !== 5'd3 || bus.busy !== 1'b1) begin fails++; $display("FAIL simul_pre: got count=%0d busy=%b want 3 1", bus.count, bus.busy); end
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h34; bus.cmd_wdata = 8'h04;
    bus.done = 1'b1;
    tick();
    bus.cmd_valid = 1'b0; bus.done = 1'b0;
    tests++; if (bus.count !== 5'd3) begin fails++; $display("FAIL simul_push_pop: got count=%0d want 3", bus.count); end
    for (int k = 5; k <= 8; k++) begin
      wait_start(ok);
      finish_txn(8'h00);
      push(1'b1, 8'(8'h30 + k), 8'(k), ok);
      tests++; if (!ok) begin fails++; $display("FAIL simul_push%0d: got not-accepted want accepted", k); end
    end
    for (int k = 0; k < 4; k++) begin
      wait_start(ok);
      finish_txn(8'h00);
    end
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL simul_drained: got count=%0d want 0", bus.count); end
    tests++; if (issued.size() != base + 8) begin fails++; $display("FAIL simul_issue_count: got %0d want 8", issued.size() - base); end
    for (int k = 0; k < 8 && base + k < issued.size(); k++) begin
      tests++; if (issued[base + k] !== 8'(8'h31 + k)) begin fails++; $display("FAIL simul_order%0d: got %h want %h", k, issued[base + k], 8'(8'h31 + k)); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int k = 1; k <= 3; k++) push(1'b1, 8'(8'h40 + k), 8'(k), ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (bus.count !== 5'd0 || bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL rstmid_count: got count=%0d rdy=%b want 0 1", bus.count, bus.cmd_ready); end
    tests++; if ({bus.start_write, bus.start_read, bus.busy} !== 3'b0 || bus.addr !== 8'h00)
      begin fails++; $display("FAIL rstmid_outputs: got %b addr=%h want 000 00", {bus.start_write, bus.start_read, bus.busy}, bus.addr); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    tests++; if (bus.count !== 5'd0 || bus.busy !== 1'b0 || bus.start_write !== 1'b0)
      begin fails++; $display("FAIL rstmid_late_done: got count=%0d busy=%b sw=%b want 0 0 0", bus.count, bus.busy, bus.start_write); end
    push(1'b1, 8'h55, 8'h66, ok);
    wait_start(ok);
    tests++; if (!ok || bus.start_write !== 1'b1 || bus.addr !== 8'h55 || bus.wdata !== 8'h66)
      begin fails++; $display("FAIL rstmid_next: got sw=%b %h/%h want 1 55/66", bus.start_write, bus.addr, bus.wdata); end
    finish_txn(8'h00);
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL rstmid_next_done: got count=%0d want 0", bus.count); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    push(1'b1, 8'h61, 8'h01, ok);
    push(1'b1, 8'h62, 8'h02, ok);
    wait_start(ok);
    tests++; if (!ok || bus.addr !== 8'h61) begin fails++; $display("FAIL tmo_first_issue: got %h want 61", bus.addr); end
`ifdef APB_CMD_TIMEOUT_EN
    for (int i = 0; i < int'(TIMEOUT); i++) tick();
    tests++; if (bus.busy !== 1'b1 || bus.err_timeout !== 1'b0 || bus.count !== 5'd2)
      begin fails++; $display("FAIL tmo_before: got busy=%b err=%b count=%0d want 1 0 2", bus.busy, bus.err_timeout, bus.count); end
    tick();
    tests++; if (bus.err_timeout !== 1'b1 || bus.count !== 5'd1 || bus.busy !== 1'b0)
      begin fails++; $display("FAIL tmo_expire: got err=%b count=%0d busy=%b want 1 1 0", bus.err_timeout, bus.count, bus.busy); end
    tick();
    tests++; if (bus.start_write !== 1'b1 || bus.addr !== 8'h62) begin fails++; $display("FAIL tmo_next_issue: got sw=%b a=%h want 1 62", bus.start_write, bus.addr); end
    finish_txn(8'h00);
    tests++; if (bus.err_timeout !== 1'b1 || bus.count !== 5'd0) begin fails++; $display("FAIL tmo_sticky: got err=%b count=%0d want 1 0", bus.err_timeout, bus.count); end
    push(1'b0, 8'h63, 8'h00, ok);
    wait_start(ok);
    for (int i = 0; i <= int'(TIMEOUT); i++) tick();
    tests++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 5'd0)
      begin fails++; $display("FAIL tmo_read_norsp: got v=%b busy=%b count=%0d want 0 0 0", bus.rsp_valid, bus.busy, bus.count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (bus.err_timeout !== 1'b0) begin fails++; $display("FAIL tmo_reset_clear: got %b want 0", bus.err_timeout); end
`else
    for (int i = 0; i < 40; i++) tick();
    tests++; if (bus.busy !== 1'b1 || bus.count !== 5'd2 || bus.err_timeout !== 1'b0 || bus.start_write !== 1'b0)
      begin fails++; $display("FAIL tmo_disabled_wait: got busy=%b count=%0d err=%b sw=%b want 1 2 0 0", bus.busy, bus.count, bus.err_timeout, bus.start_write); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    wait_start(ok);
    tests++; if (!ok || bus.addr !== 8'h62) begin fails++; $display("FAIL tmo_disabled_next: got %h want 62", bus.addr); end
    finish_txn(8'h00);
    tests++; if (bus.count !== 5'd0 || bus.err_timeout !== 1'b0) begin fails++; $display("FAIL tmo_disabled_end: got count=%0d err=%b want 0 0", bus.count, bus.err_timeout); end
`endif
  endtask

  task automatic test_random();
    tcmd_t      mq [$];
    tcmd_t      drv_cmd;
    int         phase = 0;   // 0 engine idle, 1 transaction outstanding, 2 response pending
    int         lat = 0;
    int         n_issued = 0;
    logic [7:0] exp_rsp = 8'h00;
    logic [7:0] drv_rdata = 8'h00;
    bit drv_valid = 0, drv_seen_ready = 0, drv_done = 0, drv_rr = 0, issued_now;
    do_reset();
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (drv_valid && drv_seen_ready) mq.push_back(drv_cmd);
      if (drv_done) begin
        if (mq[0].w == 1'b0) begin phase = 2; exp_rsp = drv_rdata; end
        else phase = 0;
        void'(mq.pop_front());
      end
      if (drv_rr) phase = 0;

      tests++; if (bus.count !== 5'(mq.size())) begin fails++; $display("FAIL rand_count@%0d: got %0d want %0d", cyc, bus.count, mq.size()); end
      tests++; if (bus.cmd_ready !== (mq.size() != DEPTH)) begin fails++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, bus.cmd_ready, mq.size() != DEPTH); end
      issued_now = 1'b0;
      if (bus.start_write || bus.start_read) begin
        tests++;
        if (phase != 0 || mq.size() == 0 || bus.start_write !== mq[0].w || bus.start_read !== !mq[0].w ||
            bus.addr !== mq[0].a || bus.wdata !== (mq[0].w ? mq[0].d : 8'h00)) begin
          fails++;
          $display("FAIL rand_issue@%0d: got sw=%b sr=%b a=%h d=%h, model phase=%0d depth=%0d", cyc,
                   bus.start_write, bus.start_read, bus.addr, bus.wdata, phase, mq.size());
        end
        phase = 1; lat = $urandom_range(1, 4); issued_now = 1'b1; n_issued++;
      end
      tests++;
      if (phase == 2) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_rsp) begin fails++; $display("FAIL rand_rsp@%0d: got v=%b d=%h want 1 %h", cyc, bus.rsp_valid, bus.rsp_data, exp_rsp); end
      end else begin
        if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rand_rsp_idle@%0d: got v=%b want 0", cyc, bus.rsp_valid); end
      end

      drv_valid = (cyc < 600) && ($urandom_range(0, 99) < 45);
      drv_cmd.w = 1'($urandom); drv_cmd.a = 8'($urandom); drv_cmd.d = 8'($urandom);
      bus.cmd_valid = drv_valid; bus.cmd_write = drv_cmd.w; bus.cmd_addr = drv_cmd.a; bus.cmd_wdata = drv_cmd.d;
      drv_seen_ready = bus.cmd_ready;
      drv_done = 1'b0;
      if (phase == 1 && !issued_now) begin
        lat--;
        if (lat == 0) drv_done = 1'b1;
      end
      bus.done  = drv_done || (($urandom_range(0, 7) == 0) && (phase != 1 || issued_now));
      bus.rdata = 8'($urandom);
      drv_rdata = bus.rdata;
      drv_rr = (phase == 2) && ($urandom_range(0, 2) == 0);
      bus.rsp_ready = drv_rr || ((phase != 2) && ($urandom_range(0, 1) == 0));
      tick();
    end
    idle_inputs();
    tests++; if (mq.size() != 0 || bus.count !== 5'd0) begin fails++; $display("FAIL rand_drained: got count=%0d model=%0d want 0", bus.count, mq.size()); end
    tests++; if (n_issued < 20) begin fails++; $display("FAIL rand_activity: got %0d issues want >=20", n_issued); end
    tests++; if (bus.err_timeout !== 1'b0) begin fails++; $display("FAIL rand_err: got %b want 0", bus.err_timeout); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write();
    test_read_resp();
    test_fill();
    test_simul();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_cmd_queue.md
APB_CMD_QUEUE -- requirements
Module: apb_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of command queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 16, WAIT-state cycle limit (used only under REQ-030).
REQ-003 SHALL have one clock and a reset that is synchronous and active-high.
REQ-004 SHALL have ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  8  APB address.
- cmd_wdata  in  8  write data (ignored for reads).
- start_write  out  1  one-cycle write request to the transaction engine.
- start_read  out  1  one-cycle read request to the transaction engine.
- addr  out  8  address to the engine.
- wdata  out  8  write data to the engine.
- done  in  1  engine completion pulse.
- rdata  in  8  engine read data, valid with done.
- rsp_valid  out  1  read response held.
- rsp_ready  in  1  response consumed.
- rsp_data  out  8  read response data.
- count  out  5  queued entries, including the one in flight.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky timeout flag.

Function
REQ-005 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-006 SHALL drive cmd_ready = (count != DEPTH) combinationally.
REQ-007 SHALL use read and write pointers that wrap modulo DEPTH; count SHALL stay in 0..DEPTH.
REQ-008 SHALL pop the head entry only on transaction completion, per REQ-012, REQ-013 and REQ-031.
REQ-009 SHALL handle a simultaneous push and pop by leaving count unchanged and advancing both pointers.
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP:
- IDLE goes to ISSUE when count != 0.
- ISSUE lasts one cycle, then goes to WAIT.
- WAIT goes to IDLE on done for a write.
- WAIT goes to RESP on done for a read.
- RESP goes to IDLE when rsp_ready = 1.
REQ-011 SHALL, in ISSUE, assert exactly one of start_write or start_read for exactly one cycle, according to the head entry's cmd_write.
- addr and wdata SHALL equal the head entry from ISSUE through WAIT.
- wdata SHALL be 0 for reads.
REQ-012 SHALL, on done in WAIT for a write, pop the head entry.
REQ-013 SHALL, on done in WAIT for a read, capture rdata into rsp_data and pop the head entry.
REQ-014 SHALL hold rsp_valid = 1 and rsp_data stable in RESP until rsp_ready = 1; no new command SHALL issue while in RESP.
REQ-015 SHALL ignore done in IDLE, ISSUE and RESP.
REQ-016 SHALL assert start_* two cycles after the acceptance edge when the queue is empty and idle; back-to-back commands SHALL issue in FIFO order with at least one IDLE cycle between completion and the next start.
REQ-017 SHALL drive addr and wdata to 0 and both start_* to 0 in IDLE.

Reset
REQ-018 SHALL, while PRESET = 1 at a clock edge, force IDLE and clear both pointers and count.
- Outputs SHALL be 0: start_write, start_read, addr, wdata, rsp_valid, rsp_data, busy, err_timeout.
- cmd_ready SHALL be 1.
REQ-019 SHALL, on reset mid-operation, discard all queued and in-flight commands; a done arriving after reset SHALL be ignored per REQ-015.

Configuration
REQ-030 SHALL, with APB_CMD_TIMEOUT_EN defined, count cycles in WAIT and expire at TIMEOUT cycles without done.
REQ-031 SHALL, on expiry:
- set err_timeout (sticky until reset);
- pop the head entry;
- go to IDLE with no response, including for reads.
REQ-032 SHALL, without APB_CMD_TIMEOUT_EN, wait in WAIT indefinitely and tie err_timeout to 0.

Verification
REQ-040 Write(addr 0x10, data 0xAB) into an empty queue -> start_write pulses once 2 cycles later with addr 0x10 and wdata 0xAB; done -> count 0, busy 0.
REQ-041 Read(0x10), engine returns 0xAB, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data 0xAB held stable for 5 cycles, cleared the cycle after rsp_ready = 1.
REQ-042 Push 5 commands with DEPTH 4 and done stalled -> cmd_ready 0 after the 4th; the 5th is accepted only after the first done; issue order is 1..5.
REQ-043 Push on the same edge as pop with count 3 -> count stays 3; pointers wrap correctly across 2×DEPTH commands.
REQ-044 PRESET asserted during WAIT with 3 queued -> count 0, start_* 0, a late done ignored, and the next command issues normally.
REQ-045 With APB_CMD_TIMEOUT_EN, TIMEOUT 16 and done never asserted -> err_timeout = 1 after 16 WAIT cycles, entry popped, next entry issued; without the macro -> FSM stays in WAIT and err_timeout = 0.
